adpll_phase_detector: RTL and testbench

Digital phase/frequency detector forming the front stage of the ADPLL. Synchronises the asynchronous `ref_signal` and `feedback_signal` inputs into the `clk` domain and detects their rising edges. Measures the signed lead/lag between paired rising edges in `clk` cycles and emits one registered error sample per comparison to the downstream loop filter. Also drives bang-bang `up`/`dn` levels.

---
 rtl/adpll_pkg.sv | 18 +
 rtl/adpll_sync_edge.sv | 30 +++
 rtl/adpll_phase_detector.sv | 194 +++++++++++++++++++
 tb/tb_adpll_phase_detector.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Shared types and helpers for the ADPLL phase/frequency detector front end.
// Holds the comparison FSM state encoding, the default error width and the saturation limit.
package adpll_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REF_LEAD = 2'd1,
        FB_LEAD  = 2'd2
    } pd_state_e;

    localparam int ADPLL_ERR_W = 12;

    // Largest magnitude representable by a signed error of err_w bits.
    function automatic int err_sat_limit(input int err_w);
        return int'((32'sd1 <<< (err_w - 32'sd1)) - 32'sd1);
    endfunction

endpackage

// File: rtl/adpll_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input followed by a rising-edge detector.
// The edge_pulse output is high for exactly one clk cycle per synchronised rising edge.
module adpll_sync_edge
    import adpll_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   edge_r;

    // Synchroniser chain plus previous-value register for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= '0;
            edge_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            edge_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_r[SYNC_STAGES-1] & ~edge_r;

endmodule

// File: rtl/adpll_phase_detector.sv
// ADPLL phase/frequency detector: measures signed lead/lag between ref and feedback edges
// in clk cycles, with slip/timeout saturation. Optional lock detector under ADPLL_PD_LOCK_DET_EN.
module adpll_phase_detector
    import adpll_pkg::*;
#(
    parameter int ERR_W       = ADPLL_ERR_W,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_CNT    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ref_signal,
    input  logic                    feedback_signal,
    output logic signed [ERR_W-1:0] phase_err,
    output logic                    err_valid,
    output logic                    err_sat,
    output logic                    up,
    output logic                    dn,
    output logic                    locked
);

    localparam int CNT_W = ERR_W - 1;
    localparam logic [CNT_W-1:0]        CNT_MAX     = CNT_W'(err_sat_limit(ERR_W));
    localparam logic signed [ERR_W-1:0] ERR_POS_SAT = ERR_W'(err_sat_limit(ERR_W));
    localparam logic signed [ERR_W-1:0] ERR_NEG_SAT = -ERR_POS_SAT;

    logic                    ref_p_s;
    logic                    fb_p_s;
    pd_state_e               state_r;
    pd_state_e               state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_nxt_s;
    logic                    emit_s;
    logic signed [ERR_W-1:0] emit_err_s;
    logic                    emit_sat_s;
    logic signed [ERR_W-1:0] phase_err_r;
    logic                    err_valid_r;
    logic                    err_sat_r;
    logic                    up_r;
    logic                    dn_r;

    adpll_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (ref_signal),
        .edge_pulse (ref_p_s)
    );

    adpll_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (feedback_signal),
        .edge_pulse (fb_p_s)
    );

    // Comparison FSM: next state, cycle counter and error sample to emit.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        emit_s      = 1'b0;
        emit_err_s  = '0;
        emit_sat_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (ref_p_s && fb_p_s) begin
                    emit_s = 1'b1;
                end else if (ref_p_s) begin
                    state_nxt_s = REF_LEAD;
                    cnt_nxt_s   = CNT_W'(1'b1);
                end else if (fb_p_s) begin
                    state_nxt_s = FB_LEAD;
                    cnt_nxt_s   = CNT_W'(1'b1);
                end else begin
                    cnt_nxt_s   = '0;
                end
            end
            REF_LEAD: begin
                // Lag edge wins over a simultaneous repeat of the lead edge.
                if (fb_p_s) begin
                    emit_s      = 1'b1;
                    emit_err_s  = $signed({1'b0, cnt_r});
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end else if (ref_p_s) begin
                    emit_s      = 1'b1;
                    emit_err_s  = ERR_POS_SAT;
                    emit_sat_s  = 1'b1;
                    cnt_nxt_s   = CNT_W'(1'b1);
                end else if (cnt_r == CNT_MAX) begin
                    emit_s      = 1'b1;
                    emit_err_s  = ERR_POS_SAT;
                    emit_sat_s  = 1'b1;
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1'b1);
                end
            end
            FB_LEAD: begin
                if (ref_p_s) begin
                    emit_s      = 1'b1;
                    emit_err_s  = -$signed({1'b0, cnt_r});
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end else if (fb_p_s) begin
                    emit_s      = 1'b1;
                    emit_err_s  = ERR_NEG_SAT;
                    emit_sat_s  = 1'b1;
                    cnt_nxt_s   = CNT_W'(1'b1);
                end else if (cnt_r == CNT_MAX) begin
                    emit_s      = 1'b1;
                    emit_err_s  = ERR_NEG_SAT;
                    emit_sat_s  = 1'b1;
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1'b1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; phase_err holds between strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            phase_err_r <= '0;
            err_valid_r <= 1'b0;
            err_sat_r   <= 1'b0;
            up_r        <= 1'b0;
            dn_r        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            err_valid_r <= emit_s;
            err_sat_r   <= emit_sat_s;
            up_r        <= (state_nxt_s == REF_LEAD);
            dn_r        <= (state_nxt_s == FB_LEAD);
            if (emit_s) begin
                phase_err_r <= emit_err_s;
            end
        end
    end

    assign phase_err = phase_err_r;
    assign err_valid = err_valid_r;
    assign err_sat   = err_sat_r;
    assign up        = up_r;
    assign dn        = dn_r;

`ifdef ADPLL_PD_LOCK_DET_EN
    localparam int STREAK_W = $clog2(LOCK_CNT + 1);

    logic [STREAK_W-1:0] streak_r;
    logic                locked_r;
    logic [ERR_W-1:0]    err_abs_s;
    logic                in_tol_s;

    // Magnitude of the current sample and its tolerance qualification.
    always_comb begin
        err_abs_s = phase_err_r[ERR_W-1] ? ERR_W'(-phase_err_r) : ERR_W'(phase_err_r);
        in_tol_s  = !err_sat_r && (err_abs_s <= ERR_W'(LOCK_TOL));
    end

    // Streak of consecutive in-tolerance samples driving the lock flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_r <= '0;
            locked_r <= 1'b0;
        end else if (err_valid_r) begin
            if (in_tol_s) begin
                if (streak_r != STREAK_W'(LOCK_CNT)) begin
                    streak_r <= streak_r + STREAK_W'(1'b1);
                end
                locked_r <= (streak_r >= STREAK_W'(LOCK_CNT - 1));
            end else begin
                streak_r <= '0;
                locked_r <= 1'b0;
            end
        end
    end

    assign locked = locked_r;
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_adpll_phase_detector.sv
// Directed self-checking bench for adpll_phase_detector (ERR_W=6) with an expected-sample queue.
// Lock expectations follow ADPLL_PD_LOCK_DET_EN when defined.
module tb_adpll_phase_detector;

    localparam int ERR_W = 6;
    localparam int SAT   = 31;
`ifdef ADPLL_PD_LOCK_DET_EN
    localparam int LOCK_ON = 1;
`else
    localparam int LOCK_ON = 0;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    ref_signal;
    logic                    feedback_signal;
    logic signed [ERR_W-1:0] phase_err;
    logic                    err_valid;
    logic                    err_sat;
    logic                    up;
    logic                    dn;
    logic                    locked;

    typedef struct {
        int   err;
        logic sat;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   up_cnt;
    int   dn_cnt;

    adpll_phase_detector #(
        .ERR_W       (ERR_W),
        .SYNC_STAGES (2),
        .LOCK_TOL    (2),
        .LOCK_CNT    (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ref_signal      (ref_signal),
        .feedback_signal (feedback_signal),
        .phase_err       (phase_err),
        .err_valid       (err_valid),
        .err_sat         (err_sat),
        .up              (up),
        .dn              (dn),
        .locked          (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Three-cycle high pulse on the input starting at pattern cycle 'at'.
    function automatic logic [127:0] mk(input int at);
        logic [127:0] v;
        v = 128'd7;
        return v << at;
    endfunction

    task automatic expect_err(input int e, input logic s);
        exp_t x;
        x.err = e;
        x.sat = s;
        sb_q.push_back(x);
    endtask

    task automatic drive(input logic [127:0] rp, input logic [127:0] fp, input int len);
        exp_t x;
        up_cnt = 0;
        dn_cnt = 0;
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            ref_signal      = rp[c];
            feedback_signal = fp[c];
            @(negedge clk);
            up_cnt += int'(up);
            dn_cnt += int'(dn);
            check("up_dn_exclusive", int'(up & dn), 0);
            if (err_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_strobe", int'($signed(phase_err)), 999);
                end else begin
                    x = sb_q.pop_front();
                    check("phase_err", int'($signed(phase_err)), x.err);
                    check("err_sat", int'(err_sat), int'(x.sat));
                end
            end
        end
    endtask

    initial begin
        reset           = 1'b0;
        ref_signal      = 1'b0;
        feedback_signal = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_phase_err", int'($signed(phase_err)), 0);
        check("rst_err_valid", int'(err_valid), 0);
        check("rst_up_dn", int'({up, dn}), 0);
        check("rst_locked", int'(locked), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        expect_err(25, 1'b0);
        drive(mk(0), mk(25), 35);
        check("ref_lead_up_cycles", up_cnt, 25);
        check("ref_lead_dn_cycles", dn_cnt, 0);

        expect_err(-7, 1'b0);
        drive(mk(7), mk(0), 16);
        check("fb_lead_dn_cycles", dn_cnt, 7);
        check("fb_lead_up_cycles", up_cnt, 0);

        expect_err(0, 1'b0);
        drive(mk(0), mk(0), 10);
        check("simul_up_cycles", up_cnt, 0);
        check("simul_dn_cycles", dn_cnt, 0);

        expect_err(5, 1'b0);
        drive(mk(0) | mk(5), mk(5), 14);
        check("lag_wins_up_cycles", up_cnt, 5);

        expect_err(SAT, 1'b1);
        expect_err(SAT, 1'b1);
        drive(mk(0) | mk(10), 128'd0, 52);
        check("slip_timeout_up_cycles", up_cnt, 41);

        expect_err(-SAT, 1'b1);
        drive(128'd0, mk(0), 40);
        check("fb_timeout_dn_cycles", dn_cnt, 31);

        drive(mk(0), 128'd0, 13);
        check("mid_cmp_up", int'(up), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_up", int'(up), 0);
        check("async_rst_phase_err", int'($signed(phase_err)), 0);
        check("async_rst_valid_sat", int'({err_valid, err_sat}), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        expect_err(4, 1'b0);
        drive(mk(0), mk(4), 12);
        check("post_rst_up_cycles", up_cnt, 4);

        for (int i = 0; i < 8; i++) begin
            expect_err(1, 1'b0);
            drive(mk(0), mk(1), 10);
            if (i == 6) begin
                check("locked_after_7", int'(locked), 0);
            end
        end
        check("locked_after_8", int'(locked), LOCK_ON);
        expect_err(5, 1'b0);
        drive(mk(0), mk(5), 14);
        check("locked_after_out_tol", int'(locked), 0);

        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
